nco_sweep_ctrl: RTL and testbench

- Upstream stage of the NCO core; drives its phase-increment (phi_inc_i) and frequency-modulation (freq_mod_i) inputs.
- Generates a stepped linear frequency sweep from f_start to f_stop in increments of f_step, holding each frequency for a programmable dwell.
- Supports single-shot and continuous (auto-restart) modes, with start/abort control and busy/done/step status for the host.

---
 rtl/nco_sweep_ctrl.sv | 143 ++++++++++++++
 tb/tb_nco_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl.sv
// Stepped linear frequency sweep generator feeding the NCO phase-increment
// and frequency-modulation inputs; single-shot or continuous, with abort.
module nco_sweep_ctrl #(
   parameter int apr  = 32,
   parameter int aprf = 32,
   parameter int dwc  = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clken,
   input  logic            start,
   input  logic            abort,
   input  logic            cont,
   input  logic [apr-1:0]  f_start,
   input  logic [apr-1:0]  f_stop,
   input  logic [apr-1:0]  f_step,
   input  logic [dwc-1:0]  dwell,
   input  logic [aprf-1:0] fm_i,
   output logic [apr-1:0]  phi_inc_o,
   output logic [aprf-1:0] freq_mod_o,
   output logic            busy,
   output logic            step_o,
   output logic            done
);

   typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, DONE = 2'd2} state_t;

   state_t          state_reg, state_next;
   logic [apr-1:0]  phi_reg, phi_next;
   logic [dwc-1:0]  dwell_cnt_reg, dwell_cnt_next;
   logic            busy_reg, busy_next;
   logic            step_reg, step_next;
   logic            done_reg, done_next;
   logic            load;
   logic [aprf-1:0] fm_reg;

   logic [apr-1:0]  f_start_s, f_stop_s, f_step_s;
   logic [dwc-1:0]  dwell_s;
   logic            cont_s;

   logic [apr:0]    sum;
   logic [apr-1:0]  sat;
   logic            at_end;

   // One extra bit on the sum so an overflowing step saturates at f_stop instead of wrapping.
   assign sum    = {1'b0, phi_reg} + {1'b0, f_step_s};
   assign sat    = (sum >= {1'b0, f_stop_s}) ? f_stop_s : sum[apr-1:0];
   assign at_end = (phi_reg >= f_stop_s) || (f_step_s == '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         phi_reg       <= '0;
         dwell_cnt_reg <= '0;
         busy_reg      <= 1'b0;
         step_reg      <= 1'b0;
         done_reg      <= 1'b0;
         fm_reg        <= '0;
         f_start_s     <= '0;
         f_stop_s      <= '0;
         f_step_s      <= '0;
         dwell_s       <= '0;
         cont_s        <= 1'b0;
      end else begin
         // Pulses clear on every clock edge so they stay one clk wide even when gated.
         step_reg <= 1'b0;
         done_reg <= 1'b0;
         if (clken) begin
            state_reg     <= state_next;
            phi_reg       <= phi_next;
            dwell_cnt_reg <= dwell_cnt_next;
            busy_reg      <= busy_next;
            step_reg      <= step_next;
            done_reg      <= done_next;
            fm_reg        <= fm_i;
            if (load) begin
               f_start_s <= f_start;
               f_stop_s  <= f_stop;
               f_step_s  <= f_step;
               dwell_s   <= dwell;
               cont_s    <= cont;
            end
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      phi_next       = phi_reg;
      dwell_cnt_next = dwell_cnt_reg;
      busy_next      = busy_reg;
      step_next      = 1'b0;
      done_next      = 1'b0;
      load           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !abort) begin
               load           = 1'b1;
               phi_next       = f_start;
               dwell_cnt_next = dwell;
               busy_next      = 1'b1;
               state_next     = DWELL;
            end
         end
         DWELL: begin
            if (abort) begin
               busy_next  = 1'b0;
               state_next = IDLE;
            end else if (dwell_cnt_reg != '0) begin
               dwell_cnt_next = dwell_cnt_reg - 1'b1;
            end else if (at_end) begin
               if (cont_s) begin
                  phi_next       = f_start_s;
                  dwell_cnt_next = dwell_s;
                  step_next      = 1'b1;
               end else begin
                  done_next  = 1'b1;
                  busy_next  = 1'b0;
                  state_next = DONE;
               end
            end else begin
               phi_next       = sat;
               dwell_cnt_next = dwell_s;
               step_next      = 1'b1;
            end
         end
         DONE: begin
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign phi_inc_o  = phi_reg;
   assign freq_mod_o = fm_reg;
   assign busy       = busy_reg;
   assign step_o     = step_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: table of single-shot sweeps with an
// expected-value queue, plus hand-written continuous/abort/reset sequences.
module tb_nco_sweep_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clken;
   logic        start;
   logic        abort;
   logic        cont;
   logic [31:0] f_start, f_stop, f_step;
   logic [15:0] dwell;
   logic [31:0] fm_i;
   logic [31:0] phi_inc_o;
   logic [31:0] freq_mod_o;
   logic        busy, step_o, done;

   int total = 0;
   int bad   = 0;
   bit gate  = 1'b0;
   bit fm_chk = 1'b0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [31:0] f_start;
      logic [31:0] f_step;
      logic [31:0] f_stop;
      logic [15:0] dwell;
      bit          gate;
      int          n_pts;
      logic [31:0] last;
   } vec_t;

   vec_t vecs[6];

   nco_sweep_ctrl #(.apr(32), .aprf(32), .dwc(16)) dut (
      .clk(clk), .reset_n(reset_n), .clken(clken), .start(start), .abort(abort),
      .cont(cont), .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
      .dwell(dwell), .fm_i(fm_i), .phi_inc_o(phi_inc_o), .freq_mod_o(freq_mod_o),
      .busy(busy), .step_o(step_o), .done(done)
   );

   initial forever #5 clk = ~clk;

   initial begin
      clken = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         clken = gate ? ~clken : 1'b1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", name, act, exp);
      end
   endtask

   // freq_mod_o must equal fm_i as sampled on the previous enabled edge.
   initial begin
      logic [31:0] fm_prev, fm_model;
      bit en_prev;
      fm_i = '0; fm_prev = '0; fm_model = '0; en_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!fm_chk) begin
            fm_i = '0; fm_prev = '0; fm_model = '0; en_prev = 1'b0;
         end else begin
            if (en_prev) fm_model = fm_prev;
            chk("freq_mod", freq_mod_o, fm_model);
            fm_prev = $urandom;
            fm_i    = fm_prev;
            en_prev = clken;
         end
      end
   end

   task automatic build_exp(input vec_t v);
      logic [32:0] nxt;
      logic [31:0] cur;
      exp_q.delete();
      cur = v.f_start;
      exp_q.push_back(cur);
      while (cur < v.f_stop && v.f_step != 0) begin
         nxt = {1'b0, cur} + {1'b0, v.f_step};
         if (nxt > {1'b0, v.f_stop}) cur = v.f_stop;
         else cur = nxt[31:0];
         exp_q.push_back(cur);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      while (!clken) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_single(input int idx, input vec_t v);
      int held, steps;
      bit en_last, step_prev, done_seen, start_busy;
      gate = v.gate;
      f_start = v.f_start; f_step = v.f_step; f_stop = v.f_stop;
      dwell = v.dwell; cont = 1'b0;
      build_exp(v);
      pulse_start();
      chk("first_value", phi_inc_o, exp_q.pop_front());
      chk("busy_start", busy, 1);
      held = 0; steps = 0; step_prev = 0; done_seen = 0; start_busy = 0;
      en_last = clken;
      for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
         @(negedge clk);
         if (start_busy) begin
            start = 1'b0;
            start_busy = 0;
         end
         if (en_last) held++;
         if (step_prev && !en_last) chk("step_width", step_o, 0);
         if (step_o) begin
            steps++;
            chk("hold_len", held, v.dwell + 1);
            if (exp_q.size() == 0) chk("extra_step", 1, 0);
            else chk("step_value", phi_inc_o, exp_q.pop_front());
            held = 0;
            // Start and new config while busy must be ignored.
            if (steps == 1) begin
               start = 1'b1; start_busy = 1;
               f_start = 32'h5; f_stop = 32'hFFFF_FFFF; f_step = 32'h1;
               dwell = 16'd7; cont = 1'b1;
            end
         end
         if (done) begin
            done_seen = 1;
            chk("hold_last", held, v.dwell + 1);
            chk("busy_at_done", busy, 0);
            chk("final_value", phi_inc_o, v.last);
            chk("point_count", steps + 1, v.n_pts);
            chk("queue_empty", exp_q.size(), 0);
         end
         step_prev = step_o;
         en_last = clken;
      end
      start = 1'b0;
      if (!done_seen) chk("done_timeout", 0, 1);
      @(negedge clk);
      chk("done_width", done, 0);
      repeat (4) @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_phi", phi_inc_o, v.last);
      $display("vec %0d: f_start=%0h f_step=%0h f_stop=%0h dwell=%0d gate=%0b steps=%0d final=%0h",
               idx, v.f_start, v.f_step, v.f_stop, v.dwell, v.gate, steps, phi_inc_o);
      gate = 1'b0;
   endtask

   initial begin
      int held, n;
      vecs[0] = '{32'd100, 32'd50, 32'd300, 16'd2, 1'b0, 5, 32'd300};
      vecs[1] = '{32'hFFFF_FF00, 32'h80, 32'hFFFF_FFF0, 16'd0, 1'b0, 3, 32'hFFFF_FFF0};
      vecs[2] = '{32'd100, 32'd50, 32'd300, 16'd2, 1'b1, 5, 32'd300};
      vecs[3] = '{32'd7, 32'd0, 32'd1000, 16'd4, 1'b0, 1, 32'd7};
      vecs[4] = '{32'd500, 32'd10, 32'd200, 16'd1, 1'b0, 1, 32'd500};
      vecs[5] = '{32'd0, 32'd3, 32'd10, 16'd0, 1'b0, 5, 32'd10};

      reset_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
      f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
      repeat (3) @(negedge clk);
      chk("rst_phi", phi_inc_o, 0);
      chk("rst_fm", freq_mod_o, 0);
      chk("rst_busy", busy, 0);
      chk("rst_step", step_o, 0);
      chk("rst_done", done, 0);
      reset_n = 1'b1;
      fm_chk = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_single(i, vecs[i]);

      // start and abort together in IDLE: nothing may start.
      f_start = 32'd77; f_step = 32'd1; f_stop = 32'd90; dwell = 16'd0; cont = 1'b0;
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("sa_busy", busy, 0);
         chk("sa_phi", phi_inc_o, 32'd10);
         chk("sa_step", step_o, 0);
      end
      $display("start+abort in idle: busy=%0b phi=%0d", busy, phi_inc_o);

      // Continuous sweep with restart, then abort while at 20.
      f_start = 32'd10; f_step = 32'd10; f_stop = 32'd30; dwell = 16'd1; cont = 1'b1;
      exp_q.delete();
      exp_q.push_back(32'd10); exp_q.push_back(32'd20); exp_q.push_back(32'd30);
      exp_q.push_back(32'd10); exp_q.push_back(32'd20);
      pulse_start();
      chk("cont_first", phi_inc_o, exp_q.pop_front());
      held = 0; n = 0;
      for (int cyc = 0; cyc < 100 && exp_q.size() != 0; cyc++) begin
         @(negedge clk);
         held++;
         chk("cont_no_done", done, 0);
         if (step_o) begin
            n++;
            chk("cont_hold", held, 2);
            chk("cont_value", phi_inc_o, exp_q.pop_front());
            held = 0;
         end
      end
      if (exp_q.size() != 0) chk("cont_timeout", 0, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_phi", phi_inc_o, 32'd20);
      chk("abort_step", step_o, 0);
      chk("abort_done", done, 0);
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_done", done, 0);
         chk("abort_hold", phi_inc_o, 32'd20);
      end
      $display("continuous: steps=%0d aborted at phi=%0d busy=%0b", n, phi_inc_o, busy);

      // Asynchronous reset mid-dwell, between clock edges.
      fm_chk = 1'b0;
      f_start = 32'd100; f_step = 32'd50; f_stop = 32'd300; dwell = 16'd2; cont = 1'b0;
      pulse_start();
      n = 0;
      for (int cyc = 0; cyc < 100 && n < 2; cyc++) begin
         @(negedge clk);
         if (step_o) n++;
      end
      if (n < 2) chk("rst_wait_timeout", 0, 1);
      chk("pre_reset_phi", phi_inc_o, 32'd200);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_phi", phi_inc_o, 0);
      chk("arst_busy", busy, 0);
      chk("arst_step", step_o, 0);
      chk("arst_done", done, 0);
      chk("arst_fm", freq_mod_o, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("post_rst_busy", busy, 0);
         chk("post_rst_phi", phi_inc_o, 0);
      end
      $display("async reset: phi=%0d busy=%0b", phi_inc_o, busy);
      fm_chk = 1'b1;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
